// File: rtl/reset_seq_gen.sv
// reset_seq_gen: pixel-clock reset sequencer for the video pipeline.
// Synchronises and debounces PLL lock, then releases NUM_STAGES active-low
// resets in order, STAGE_DELAY cycles apart. All resets drop again on lock
// loss or a software request. A saturating counter records lock losses seen
// while releasing or running.
//
// Request semantics: sw_reset is a one-cycle, fire-and-forget request with
// no ready/acknowledge. It is sampled on every rising edge. It takes effect
// only in RELEASE or RUN while the synchronised lock is high. In WAIT_LOCK and
// FILTER it is dropped silently. When lock loss and sw_reset arrive in the
// same cycle, lock loss wins.
//
// Debug visibility: state_q, fcnt_q, idx_q and dcnt_q are plain flops with
// stable names, so checkers can bind to them hierarchically.

module reset_seq_gen #(
    parameter int NUM_STAGES  = 3,
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_FILTER = 8,
    parameter int STAGE_DELAY = 15
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  pll_lock,
    input  logic                  sw_reset,
    output logic [NUM_STAGES-1:0] stage_resetn,
    output logic                  all_released,
    output logic                  busy,
    output logic [7:0]            lock_lost_cnt
);

    // Counter widths: enough bits for each counter's largest value, and at
    // least one bit.
    localparam int FW = (LOCK_FILTER > 1) ? $clog2(LOCK_FILTER) : 1;
    localparam int DW = (STAGE_DELAY > 1) ? $clog2(STAGE_DELAY) : 1;
    localparam int IW = (NUM_STAGES  > 1) ? $clog2(NUM_STAGES)  : 1;

    localparam logic [FW-1:0] FCNT_MAX = FW'(LOCK_FILTER - 1);
    localparam logic [DW-1:0] DCNT_MAX = DW'(STAGE_DELAY - 1);
    localparam logic [IW-1:0] IDX_MAX  = IW'(NUM_STAGES - 1);
    localparam logic [7:0]    CNT_SAT  = 8'hFF;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        FILTER    = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } state_e;

    // Synchroniser chain; the last flop is the clean lock_s.
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   lock_s;

    state_e                 state_q, state_d;
    logic [FW-1:0]          fcnt_q, fcnt_d;
    logic [DW-1:0]          dcnt_q, dcnt_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [NUM_STAGES-1:0]  stage_q, stage_d;
    logic                   all_rel_q, all_rel_d;
    logic                   busy_q, busy_d;
    logic [7:0]             cnt_q, cnt_d;

    assign lock_s = sync_q[SYNC_STAGES-1];

    // Shift the asynchronous lock input into the synchroniser chain.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], pll_lock};
    end

    // State and output registers; resetn clears everything asynchronously.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_q    <= '0;
            state_q   <= WAIT_LOCK;
            fcnt_q    <= '0;
            dcnt_q    <= '0;
            idx_q     <= '0;
            stage_q   <= '0;
            all_rel_q <= 1'b0;
            busy_q    <= 1'b1;
            cnt_q     <= '0;
        end else begin
            sync_q    <= sync_d;
            state_q   <= state_d;
            fcnt_q    <= fcnt_d;
            dcnt_q    <= dcnt_d;
            idx_q     <= idx_d;
            stage_q   <= stage_d;
            all_rel_q <= all_rel_d;
            busy_q    <= busy_d;
            cnt_q     <= cnt_d;
        end
    end

    // Next-state logic: lock filtering, staged release, lock-loss and
    // software-restart handling. Registered outputs are computed here too.
    always_comb begin
        state_d   = state_q;
        fcnt_d    = fcnt_q;
        dcnt_d    = dcnt_q;
        idx_d     = idx_q;
        stage_d   = stage_q;
        all_rel_d = all_rel_q;
        cnt_d     = cnt_q;

        case (state_q)
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = FILTER;
                    fcnt_d  = '0;
                end
            end

            FILTER: begin
                if (!lock_s) begin
                    // A glitch during filtering is not counted as a loss.
                    state_d   = WAIT_LOCK;
                    stage_d   = '0;
                    all_rel_d = 1'b0;
                end else if (fcnt_q == FCNT_MAX) begin
                    state_d = RELEASE;
                    idx_d   = '0;
                    dcnt_d  = '0;
                end else begin
                    fcnt_d = fcnt_q + 1'b1;
                end
            end

            RELEASE, RUN: begin
                if (!lock_s) begin
                    state_d   = WAIT_LOCK;
                    stage_d   = '0;
                    all_rel_d = 1'b0;
                    if (cnt_q != CNT_SAT) begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end else if (sw_reset) begin
                    state_d   = RELEASE;
                    idx_d     = '0;
                    dcnt_d    = '0;
                    stage_d   = '0;
                    all_rel_d = 1'b0;
                end else if (state_q == RELEASE) begin
                    if (dcnt_q == DCNT_MAX) begin
                        dcnt_d = '0;
                        // Release only the stage at idx. Bits are filled
                        // from 0 upward, so the output stays a thermometer
                        // code.
                        for (int k = 0; k < NUM_STAGES; k++) begin
                            if (idx_q == IW'(k)) begin
                                stage_d[k] = 1'b1;
                            end
                        end
                        if (idx_q == IDX_MAX) begin
                            state_d   = RUN;
                            all_rel_d = 1'b1;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else begin
                        dcnt_d = dcnt_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d   = WAIT_LOCK;
                stage_d   = '0;
                all_rel_d = 1'b0;
            end
        endcase

        busy_d = (state_d != RUN);
    end

    assign stage_resetn  = stage_q;
    assign all_released  = all_rel_q;
    assign busy          = busy_q;
    assign lock_lost_cnt = cnt_q;

endmodule

// File: tb/tb_reset_seq_gen.sv
// Testbench for reset_seq_gen at default parameters. Expected release edges
// are pushed to a scoreboard when lock (or sw_reset) is driven, then popped
// and compared as stage_resetn transitions are observed.

module tb_reset_seq_gen;

    localparam int NS = 3;
    localparam int SS = 2;
    localparam int LF = 8;
    localparam int SD = 15;

    logic          clk;
    logic          resetn;
    logic          pll_lock;
    logic          sw_reset;
    logic [NS-1:0] stage_resetn;
    logic          all_released;
    logic          busy;
    logic [7:0]    lock_lost_cnt;

    int n_checks = 0;
    int n_pass   = 0;
    int edge_no  = 0;
    int ar_edge  = -1;
    int bz_edge  = -1;
    int exp_cnt  = 0;
    bit mono_en  = 1'b0;

    logic [NS-1:0] last_stage;
    logic [NS-1:0] exp_q[$];
    int            exp_t_q[$];
    logic [NS-1:0] obs_q[$];
    int            obs_t_q[$];

    reset_seq_gen #(
        .NUM_STAGES (NS),
        .SYNC_STAGES(SS),
        .LOCK_FILTER(LF),
        .STAGE_DELAY(SD)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .pll_lock     (pll_lock),
        .sw_reset     (sw_reset),
        .stage_resetn (stage_resetn),
        .all_released (all_released),
        .busy         (busy),
        .lock_lost_cnt(lock_lost_cnt)
    );

    // ---------------- clock / watchdog ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, n_pass=%0d n_checks=%0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    // stage_resetn must always be a thermometer code (bit k high implies bit k-1 high).
    always @(negedge clk) begin
        if (mono_en && resetn === 1'b1) begin
            n_checks++;
            if ((((stage_resetn + 1'b1) & stage_resetn) !== '0) || $isunknown(stage_resetn))
                $display("FAIL monotone: stage_resetn=%b is not a thermometer code", stage_resetn);
            else
                n_pass++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        resetn   = 1'b0;
        pll_lock = 1'b0;
        sw_reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        repeat (2) @(posedge clk);
        exp_cnt = 0;
    endtask

    // Raise lock at a negedge; the following posedge is edge 0.
    task automatic start_lock();
        @(negedge clk);
        pll_lock = 1'b1;
        @(posedge clk);
        edge_no = 0;
        #1;
        last_stage = stage_resetn;
        ar_edge = -1;
        bz_edge = -1;
    endtask

    // Scoreboard push: stage k is expected at base + (k+1)*SD as a thermometer code.
    task automatic push_release(input int base);
        logic [NS-1:0] m;
        for (int k = 0; k < NS; k++) begin
            m = NS'((1 << (k + 1)) - 1);
            exp_q.push_back(m);
            exp_t_q.push_back(base + (k + 1) * SD);
        end
    endtask

    // Monitor: record stage_resetn transitions (value, edge number) for up to budget edges.
    task automatic collect(input int budget, input int want);
        for (int i = 0; i < budget && obs_q.size() < want; i++) begin
            @(posedge clk);
            edge_no++;
            #1;
            if (stage_resetn !== last_stage) begin
                obs_q.push_back(stage_resetn);
                obs_t_q.push_back(edge_no);
                last_stage = stage_resetn;
            end
            if (all_released === 1'b1 && ar_edge < 0) ar_edge = edge_no;
            if (busy === 1'b0 && bz_edge < 0) bz_edge = edge_no;
        end
    endtask

    task automatic wait_released(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(posedge clk);
            #1;
            if (all_released === 1'b1) ok = 1'b1;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        resetn   = 1'b1;
        pll_lock = 1'b1;
        sw_reset = 1'b0;
        #3 resetn = 1'b0;
        #1;
        n_checks++; if (stage_resetn !== '0) $display("FAIL rst_stage: got %b want 000", stage_resetn); else n_pass++;
        n_checks++; if (all_released !== 1'b0) $display("FAIL rst_all: got %b want 0", all_released); else n_pass++;
        n_checks++; if (busy !== 1'b1) $display("FAIL rst_busy: got %b want 1", busy); else n_pass++;
        n_checks++; if (lock_lost_cnt !== 8'd0) $display("FAIL rst_cnt: got %0d want 0", lock_lost_cnt); else n_pass++;
        repeat (4) @(posedge clk);
        #1;
        n_checks++; if (stage_resetn !== '0 || busy !== 1'b1) $display("FAIL rst_hold: stage=%b busy=%b want 000/1", stage_resetn, busy); else n_pass++;
        mono_en = 1'b1;
    endtask

    task automatic test_power_up();
        logic [NS-1:0] ev, ov;
        int et, ot;
        do_reset();
        start_lock();
        push_release(SS + LF);
        obs_q.delete(); obs_t_q.delete();
        collect(80, NS);
        while (exp_q.size() > 0) begin
            ev = exp_q.pop_front(); et = exp_t_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) $display("FAIL pwr_seq: no transition, want %b at edge %0d", ev, et);
            else begin
                ov = obs_q.pop_front(); ot = obs_t_q.pop_front();
                if (ov !== ev || ot !== et) $display("FAIL pwr_seq: got %b at edge %0d, want %b at edge %0d", ov, ot, ev, et);
                else n_pass++;
            end
        end
        n_checks++; if (ar_edge !== SS + LF + NS * SD) $display("FAIL pwr_all_rel: rose at edge %0d want %0d", ar_edge, SS + LF + NS * SD); else n_pass++;
        n_checks++; if (bz_edge !== SS + LF + NS * SD) $display("FAIL pwr_busy: fell at edge %0d want %0d", bz_edge, SS + LF + NS * SD); else n_pass++;
    endtask

    task automatic test_glitch();
        logic [NS-1:0] ev, ov;
        int et, ot;
        do_reset();
        obs_q.delete(); obs_t_q.delete();
        @(negedge clk);
        pll_lock = 1'b1;
        last_stage = stage_resetn;
        collect(5, 1);
        @(negedge clk);
        pll_lock = 1'b0;
        collect(3, 1);
        n_checks++; if (obs_q.size() != 0) $display("FAIL glitch_norel: %0d transitions seen, want 0", obs_q.size()); else n_pass++;
        n_checks++; if (lock_lost_cnt !== 8'd0) $display("FAIL glitch_cnt: got %0d want 0", lock_lost_cnt); else n_pass++;
        start_lock();
        push_release(SS + LF);
        obs_q.delete(); obs_t_q.delete();
        collect(80, NS);
        while (exp_q.size() > 0) begin
            ev = exp_q.pop_front(); et = exp_t_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) $display("FAIL glitch_seq: no transition, want %b at edge %0d", ev, et);
            else begin
                ov = obs_q.pop_front(); ot = obs_t_q.pop_front();
                if (ov !== ev || ot !== et) $display("FAIL glitch_seq: got %b at edge %0d, want %b at edge %0d", ov, ot, ev, et);
                else n_pass++;
            end
        end
    endtask

    task automatic test_lock_loss();
        logic [NS-1:0] ev, ov;
        int et, ot, clr_edge;
        // Enters in RUN from the previous test.
        @(negedge clk);
        pll_lock = 1'b0;
        edge_no = 0;
        clr_edge = -1;
        for (int i = 0; i < 10 && clr_edge < 0; i++) begin
            @(posedge clk);
            edge_no++;
            #1;
            if (stage_resetn === '0 && all_released === 1'b0) clr_edge = edge_no;
        end
        if (exp_cnt < 255) exp_cnt++;
        n_checks++; if (clr_edge !== SS + 1) $display("FAIL loss_clear: cleared at edge %0d want %0d", clr_edge, SS + 1); else n_pass++;
        n_checks++; if (busy !== 1'b1) $display("FAIL loss_busy: got %b want 1", busy); else n_pass++;
        n_checks++; if (lock_lost_cnt !== 8'(exp_cnt)) $display("FAIL loss_cnt: got %0d want %0d", lock_lost_cnt, exp_cnt); else n_pass++;
        start_lock();
        push_release(SS + LF);
        obs_q.delete(); obs_t_q.delete();
        collect(80, NS);
        while (exp_q.size() > 0) begin
            ev = exp_q.pop_front(); et = exp_t_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) $display("FAIL relock_seq: no transition, want %b at edge %0d", ev, et);
            else begin
                ov = obs_q.pop_front(); ot = obs_t_q.pop_front();
                if (ov !== ev || ot !== et) $display("FAIL relock_seq: got %b at edge %0d, want %b at edge %0d", ov, ot, ev, et);
                else n_pass++;
            end
        end
    endtask

    task automatic test_sw_reset();
        logic [NS-1:0] ev, ov;
        int et, ot;
        // Enters in RUN with lock high.
        repeat (3) @(posedge clk);
        @(negedge clk);
        sw_reset = 1'b1;
        @(posedge clk);
        edge_no = 0;
        #1;
        sw_reset = 1'b0;
        ar_edge = -1;
        bz_edge = -1;
        n_checks++; if (stage_resetn !== '0 || all_released !== 1'b0) $display("FAIL sw_clear: stage=%b all=%b want 000/0", stage_resetn, all_released); else n_pass++;
        n_checks++; if (busy !== 1'b1) $display("FAIL sw_busy: got %b want 1", busy); else n_pass++;
        last_stage = stage_resetn;
        push_release(0);
        obs_q.delete(); obs_t_q.delete();
        collect(70, NS);
        while (exp_q.size() > 0) begin
            ev = exp_q.pop_front(); et = exp_t_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) $display("FAIL sw_seq: no transition, want %b at edge %0d", ev, et);
            else begin
                ov = obs_q.pop_front(); ot = obs_t_q.pop_front();
                if (ov !== ev || ot !== et) $display("FAIL sw_seq: got %b at edge %0d, want %b at edge %0d", ov, ot, ev, et);
                else n_pass++;
            end
        end
        n_checks++; if (ar_edge !== NS * SD) $display("FAIL sw_all_rel: rose at edge %0d want %0d", ar_edge, NS * SD); else n_pass++;
        n_checks++; if (lock_lost_cnt !== 8'(exp_cnt)) $display("FAIL sw_cnt: got %0d want %0d", lock_lost_cnt, exp_cnt); else n_pass++;
    endtask

    task automatic test_saturate();
        bit ok;
        for (int e = 0; e < 300; e++) begin
            @(negedge clk);
            pll_lock = 1'b1;
            wait_released(80, ok);
            n_checks++;
            if (!ok) begin
                $display("FAIL sat_release: iteration %0d all_released never rose", e);
                break;
            end
            n_pass++;
            @(negedge clk);
            pll_lock = 1'b0;
            repeat (SS + 2) @(posedge clk);
            #1;
            if (exp_cnt < 255) exp_cnt++;
            n_checks++;
            if (lock_lost_cnt !== 8'(exp_cnt)) $display("FAIL sat_cnt: iteration %0d got %0d want %0d", e, lock_lost_cnt, exp_cnt);
            else n_pass++;
        end
        @(negedge clk);
        pll_lock = 1'b1;
        wait_released(80, ok);
        n_checks++; if (!ok) $display("FAIL sat_relock: all_released never rose"); else n_pass++;
        @(posedge clk);
        #2 resetn = 1'b0;
        #1;
        exp_cnt = 0;
        n_checks++; if (lock_lost_cnt !== 8'd0) $display("FAIL sat_rst_cnt: got %0d want 0", lock_lost_cnt); else n_pass++;
        n_checks++; if (stage_resetn !== '0 || all_released !== 1'b0 || busy !== 1'b1)
            $display("FAIL sat_rst_out: stage=%b all=%b busy=%b want 000/0/1", stage_resetn, all_released, busy);
        else n_pass++;
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_sw_and_loss();
        bit ok;
        wait_released(80, ok);
        n_checks++; if (!ok) $display("FAIL both_prep: all_released never rose"); else n_pass++;
        @(negedge clk);
        pll_lock = 1'b0;
        repeat (SS) @(posedge clk);
        @(negedge clk);
        sw_reset = 1'b1;
        @(posedge clk);
        #1;
        sw_reset = 1'b0;
        exp_cnt++;
        n_checks++; if (stage_resetn !== '0 || all_released !== 1'b0) $display("FAIL both_clear: stage=%b all=%b want 000/0", stage_resetn, all_released); else n_pass++;
        n_checks++; if (lock_lost_cnt !== 8'(exp_cnt)) $display("FAIL both_cnt: got %0d want %0d", lock_lost_cnt, exp_cnt); else n_pass++;
        obs_q.delete(); obs_t_q.delete();
        last_stage = stage_resetn;
        collect(60, 1);
        n_checks++; if (obs_q.size() != 0) $display("FAIL both_norel: %0d transitions seen, want 0", obs_q.size()); else n_pass++;
        n_checks++; if (lock_lost_cnt !== 8'(exp_cnt)) $display("FAIL both_cnt_hold: got %0d want %0d", lock_lost_cnt, exp_cnt); else n_pass++;
    endtask

    task automatic test_reset_mid_release();
        logic [NS-1:0] ev, ov;
        int et, ot;
        start_lock();
        obs_q.delete(); obs_t_q.delete();
        collect(80, 1);
        n_checks++; if (stage_resetn !== 3'b001) $display("FAIL mid_stage0: got %b want 001", stage_resetn); else n_pass++;
        collect(5, 99);
        #2 resetn = 1'b0;
        #1;
        exp_cnt = 0;
        n_checks++; if (stage_resetn !== '0 || all_released !== 1'b0 || busy !== 1'b1 || lock_lost_cnt !== 8'd0)
            $display("FAIL mid_async: stage=%b all=%b busy=%b cnt=%0d want 000/0/1/0", stage_resetn, all_released, busy, lock_lost_cnt);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            n_checks++; if (stage_resetn !== '0) $display("FAIL mid_hold: cycle %0d got %b want 000", i, stage_resetn); else n_pass++;
        end
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        edge_no = 0;
        #1;
        last_stage = stage_resetn;
        push_release(SS + LF);
        obs_q.delete(); obs_t_q.delete();
        collect(80, NS);
        while (exp_q.size() > 0) begin
            ev = exp_q.pop_front(); et = exp_t_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) $display("FAIL mid_reseq: no transition, want %b at edge %0d", ev, et);
            else begin
                ov = obs_q.pop_front(); ot = obs_t_q.pop_front();
                if (ov !== ev || ot !== et) $display("FAIL mid_reseq: got %b at edge %0d, want %b at edge %0d", ov, ot, ev, et);
                else n_pass++;
            end
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_power_up();
        test_glitch();
        test_lock_loss();
        test_sw_reset();
        test_saturate();
        test_sw_and_loss();
        test_reset_mid_release();
        mono_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
